// File: rtl/gpio_bidir_xfer.sv
// Fabric-side transaction engine for the 8-bit bidirectional GPIO buffer:
// sequences tristate, data and strobe for byte writes/reads with a post-write turnaround.
module gpio_bidir_xfer #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned TURN_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       wr_done,
    output logic [7:0] gpio_dout,
    output logic       gpio_tristate,
    input  logic [7:0] gpio_din,
    output logic       gpio_strobe
);

    localparam int unsigned MAX_SP = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned MAX_HT = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
    localparam int unsigned MAXP   = (MAX_SP > MAX_HT) ? MAX_SP : MAX_HT;
    localparam int unsigned CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        TURN,
        RD_STROBE,
        RD_CAPTURE,
        RD_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          wr_done_q, wr_done_d;
    logic [7:0]    gpio_dout_q, gpio_dout_d;
    logic          gpio_tristate_q, gpio_tristate_d;
    logic          gpio_strobe_q, gpio_strobe_d;

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gpio_dout_d = gpio_dout_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_write) begin
                        gpio_dout_d = req_data;
                        state_d     = WR_SETUP;
                        cnt_d       = SETUP_LD;
                    end else begin
                        state_d = RD_STROBE;
                        cnt_d   = STROBE_LD;
                    end
                end
            end
            WR_SETUP: begin
                if (cnt_zero) begin
                    state_d = WR_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_STROBE: begin
                if (cnt_zero) begin
                    state_d = WR_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_HOLD: begin
                if (cnt_zero) begin
                    state_d = TURN;
                    cnt_d   = TURN_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TURN: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RD_STROBE: begin
                if (cnt_zero) begin
                    state_d = RD_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // gpio_din already lags the pins by one clk, so this holds the last strobe-cycle value.
            RD_CAPTURE: begin
                rsp_data_d = gpio_din;
                state_d    = RD_RESP;
            end
            RD_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it after the edge.
        req_ready_d     = (state_d == IDLE);
        gpio_tristate_d = !(state_d inside {WR_SETUP, WR_STROBE, WR_HOLD});
        gpio_strobe_d   = (state_d inside {WR_STROBE, RD_STROBE});
        wr_done_d       = (state_q == WR_HOLD) && (state_d == TURN);
        rsp_valid_d     = (state_d == RD_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            wr_done_q       <= 1'b0;
            gpio_dout_q     <= '0;
            gpio_tristate_q <= 1'b1;
            gpio_strobe_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            wr_done_q       <= wr_done_d;
            gpio_dout_q     <= gpio_dout_d;
            gpio_tristate_q <= gpio_tristate_d;
            gpio_strobe_q   <= gpio_strobe_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign wr_done       = wr_done_q;
    assign gpio_dout     = gpio_dout_q;
    assign gpio_tristate = gpio_tristate_q;
    assign gpio_strobe   = gpio_strobe_q;

endmodule

// File: tb/tb_gpio_bidir_xfer.sv
// Directed bench for gpio_bidir_xfer: default instance plus two parameter-sweep instances,
// each with a pin/buffer model whose registered input lags the pins by one clk.
module tb_gpio_bidir_xfer;

    localparam int NI = 3;
    localparam int SP [NI] = '{2, 1, 5};
    localparam int PP [NI] = '{2, 1, 3};
    localparam int HP [NI] = '{2, 1, 4};
    localparam int TP [NI] = '{2, 1, 6};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid     [NI];
    logic       req_ready     [NI];
    logic       req_write     [NI];
    logic [7:0] req_data      [NI];
    logic       rsp_valid     [NI];
    logic [7:0] rsp_data      [NI];
    logic       wr_done       [NI];
    logic [7:0] gpio_dout     [NI];
    logic       gpio_tristate [NI];
    logic [7:0] gpio_din      [NI];
    logic       gpio_strobe   [NI];
    logic [7:0] pin           [NI];
    logic [7:0] ext_val       [NI];

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gpio_bidir_xfer #(
            .SETUP_CYCLES (SP[g]),
            .STROBE_CYCLES(PP[g]),
            .HOLD_CYCLES  (HP[g]),
            .TURN_CYCLES  (TP[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_write    (req_write[g]),
            .req_data     (req_data[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_data     (rsp_data[g]),
            .wr_done      (wr_done[g]),
            .gpio_dout    (gpio_dout[g]),
            .gpio_tristate(gpio_tristate[g]),
            .gpio_din     (gpio_din[g]),
            .gpio_strobe  (gpio_strobe[g])
        );
    end

    always #5 clk = ~clk;

    // External device drives ext_val only while strobed and the FPGA has released the bus.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            pin[i] = !gpio_tristate[i] ? gpio_dout[i] : (gpio_strobe[i] ? ext_val[i] : 8'hC3);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) gpio_din[i] <= pin[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Status vector layout: {req_ready, gpio_tristate, gpio_strobe, wr_done, rsp_valid}
    function automatic logic [4:0] obs_vec(input int i);
        return {req_ready[i], gpio_tristate[i], gpio_strobe[i], wr_done[i], rsp_valid[i]};
    endfunction

    function automatic logic [4:0] wr_vec(input int i, input int k);
        int s, p, h, r;
        s = SP[i]; p = PP[i]; h = HP[i]; r = SP[i] + PP[i] + HP[i] + TP[i] + 1;
        return {k >= r, !(k >= 1 && k <= s + p + h), (k >= s + 1 && k <= s + p),
                k == s + p + h + 1, 1'b0};
    endfunction

    function automatic logic [4:0] rd_vec(input int i, input int k);
        int p;
        p = PP[i];
        return {k >= p + 3, 1'b1, (k >= 1 && k <= p), 1'b0, k == p + 2};
    endfunction

    // One request (optionally followed by a back-to-back read held valid), checked cycle by cycle.
    task automatic run(input int i, input bit wr, input logic [7:0] d, input bit rd_after,
                       input logic [7:0] ext, input bit offer);
        int p, first_len, last, shp;
        logic [4:0] e;
        p         = PP[i];
        shp       = SP[i] + PP[i] + HP[i];
        first_len = wr ? shp + TP[i] + 1 : p + 3;
        last      = rd_after ? first_len + p + 3 : first_len;
        @(negedge clk);
        ext_val[i]   = ext;
        req_write[i] = wr;
        req_data[i]  = d;
        req_valid[i] = 1'b1;
        chk($sformatf("u%0d ready_before_accept", i), 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        #1;
        if (rd_after) begin
            req_write[i] = 1'b0;
        end else if (offer) begin
            req_write[i] = 1'b1;
            req_data[i]  = ~d;
        end else begin
            req_valid[i] = 1'b0;
        end
        for (int k = 1; k <= last; k++) begin
            if (offer && !rd_after) req_valid[i] = (k < first_len);
            if (rd_after && k == first_len + 1) req_valid[i] = 1'b0;
            if (k <= first_len) e = wr ? wr_vec(i, k) : rd_vec(i, k);
            else e = rd_vec(i, k - first_len);
            chk($sformatf("u%0d %s c%0d status", i, wr ? "wr" : "rd", k), 32'(obs_vec(i)), 32'(e));
            if (wr && k <= shp)
                chk($sformatf("u%0d wr c%0d gpio_dout", i, k), 32'(gpio_dout[i]), 32'(d));
            if (e[0])
                chk($sformatf("u%0d c%0d rsp_data", i, k), 32'(rsp_data[i]), 32'(ext));
            @(posedge clk);
            #1;
        end
        req_valid[i] = 1'b0;
        chk($sformatf("u%0d idle_after", i), 32'(obs_vec(i)), 32'(5'b11000));
        if (wr && !rd_after)
            chk($sformatf("u%0d dout_kept", i), 32'(gpio_dout[i]), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_data[i]  = 8'h00;
            ext_val[i]   = 8'h00;
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d reset status", i), 32'(obs_vec(i)), 32'(5'b11000));
            chk($sformatf("u%0d reset dout", i), 32'(gpio_dout[i]), 32'd0);
            chk($sformatf("u%0d reset rsp_data", i), 32'(rsp_data[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0);
        run(0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
        run(0, 1'b1, 8'h5A, 1'b1, 8'h96, 1'b0);
        run(0, 1'b0, 8'h00, 1'b1, 8'h6B, 1'b0);
        run(0, 1'b1, 8'h17, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of the write strobe.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_data[0]  = 8'h99;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (SP[0]) @(posedge clk);
        #1;
        chk("u0 abort pre strobe", 32'(obs_vec(0)), 32'(wr_vec(0, SP[0] + 1)));
        chk("u0 abort pre dout", 32'(gpio_dout[0]), 32'h99);
        #2 rst = 1'b1;
        #1;
        chk("u0 abort status", 32'(obs_vec(0)), 32'(5'b11000));
        chk("u0 abort dout", 32'(gpio_dout[0]), 32'd0);
        chk("u0 abort rsp_data", 32'(rsp_data[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("u0 post_abort c%0d status", k), 32'(obs_vec(0)), 32'(5'b11000));
        end
        run(0, 1'b0, 8'h00, 1'b0, 8'hE1, 1'b0);

        run(1, 1'b1, 8'h81, 1'b0, 8'h00, 1'b1);
        run(1, 1'b0, 8'h00, 1'b0, 8'h7E, 1'b0);
        run(1, 1'b1, 8'h24, 1'b1, 8'hDB, 1'b0);

        run(2, 1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
        run(2, 1'b0, 8'h00, 1'b0, 8'h18, 1'b0);
        run(2, 1'b1, 8'hF0, 1'b1, 8'hBD, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
